// File: rtl/tot_pkg.sv
// rtl/tot_pkg.sv - shared constants, FSM encoding and hit word layout for the TOT hit assembler
//
// Purpose:
//   Common definitions imported by tot_hit_assembler and its output buffer.
//   - FINE_W       : width of the fine encoder bin code (32 bins per coarse period)
//   - FLAGS_W      : width of the hit flag field
//   - FLAG_*       : bit positions inside the flag field
//   - ST_*         : pairing FSM state encoding
//   - hit word     : {toa, tot, flags}, toa in the MSBs, flags in the LSBs
package tot_pkg;

  localparam int FINE_W  = 5;
  localparam int FLAGS_W = 3;

  // Flag field bit positions
  localparam int FLAG_LE_ERR  = 0;
  localparam int FLAG_TE_ERR  = 1;
  localparam int FLAG_TIMEOUT = 2;

  // Pairing FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_TE = 2'd1;
  localparam logic [1:0] ST_PUSH    = 2'd2;

  // Timestamp width for a given coarse counter width: {coarse, fine}
  function automatic int ts_width(input int coarse_w);
    return coarse_w + FINE_W;
  endfunction

  // Hit word width for a given timestamp width: {toa, tot, flags}
  function automatic int hit_word_width(input int ts_w);
    return 2 * ts_w + FLAGS_W;
  endfunction

  // LSB position of the tot field inside the hit word
  function automatic int tot_lsb();
    return FLAGS_W;
  endfunction

  // LSB position of the toa field inside the hit word
  function automatic int toa_lsb(input int ts_w);
    return FLAGS_W + ts_w;
  endfunction

endpackage

// File: rtl/tot_hit_fifo2.sv
// rtl/tot_hit_fifo2.sv - two-entry synchronous FIFO with asynchronous active-low reset
//
// Purpose:
//   Small output buffer for assembled hit words. The head entry is presented
//   on rdata continuously; it only changes on a pop, so a stalled consumer
//   sees a stable word.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, clears pointers and storage
//   push   in   write wdata this cycle (ignored when full and not popping)
//   wdata  in   [W-1:0] word to write
//   pop    in   remove the head entry this cycle (ignored when empty)
//   rdata  out  [W-1:0] head entry
//   full   out  both entries occupied
//   empty  out  no entry occupied
module tot_hit_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         do_push;
  logic         do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full
  // buffer is still accepted; it lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);

  assign rdata = rd_ptr ? mem1 : mem0;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) begin
          mem1 <= wdata;
        end else begin
          mem0 <= wdata;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/tot_hit_assembler.sv
// rtl/tot_hit_assembler.sv - pairs LE/TE fine codes into hit words with toa, tot and flags
//
// Purpose:
//   Sits after the TOT fine encoder. Each edge event is timestamped as
//   {coarse, fine}. A leading edge opens a hit, the following trailing edge
//   closes it (tot = ts_te - ts_le modulo 2^TS_W), or a timer closes it with
//   tot = 0 and the timeout flag. Completed words go into a 2-entry buffer
//   whose head drives the hit_* outputs under valid/ready handshaking.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   fine_valid  in   fine code present this cycle
//   fine_edge   in   0 = leading edge, 1 = trailing edge
//   fine_code   in   [4:0] fine bin code
//   fine_error  in   fine encoder error, the event's fine field is forced to 0
//   coarse      in   [COARSE_W-1:0] coarse count sampled with the edge
//   hit_valid   out  hit word available
//   hit_ready   in   consumer accepts the head word
//   hit_toa     out  [TS_W-1:0] LE timestamp
//   hit_tot     out  [TS_W-1:0] TE minus LE timestamp, modulo 2^TS_W
//   hit_flags   out  [2:0] {timeout, TE error, LE error}
//   drop_cnt    out  [OVF_W-1:0] saturating count of discarded events/words
//   busy        out  pairing FSM not idle
module tot_hit_assembler
  import tot_pkg::*;
#(
  parameter  int COARSE_W = 10,
  parameter  int TIMEOUT  = 64,
  parameter  int OVF_W    = 8,
  localparam int TS_W     = COARSE_W + FINE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fine_valid,
  input  logic                fine_edge,
  input  logic [FINE_W-1:0]   fine_code,
  input  logic                fine_error,
  input  logic [COARSE_W-1:0] coarse,
  output logic                hit_valid,
  input  logic                hit_ready,
  output logic [TS_W-1:0]     hit_toa,
  output logic [TS_W-1:0]     hit_tot,
  output logic [FLAGS_W-1:0]  hit_flags,
  output logic [OVF_W-1:0]    drop_cnt,
  output logic                busy
);

  localparam int HIT_W   = hit_word_width(ts_width(COARSE_W));
  localparam int TOT_LSB = tot_lsb();
  localparam int TOA_LSB = toa_lsb(TS_W);
  // Timer only needs to count up to TIMEOUT-1
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [TS_W-1:0]    ts_le;
  logic               err_le;
  logic [TMR_W-1:0]   timer;
  logic [TS_W-1:0]    pend_tot;
  logic [FLAGS_W-1:0] pend_flags;

  logic [FINE_W-1:0]  ev_fine;
  logic [TS_W-1:0]    ev_ts;
  logic               ev_le;
  logic               ev_te;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_accept;
  logic [HIT_W-1:0]   fifo_wdata;
  logic [HIT_W-1:0]   fifo_rdata;

  logic               ev_drop;
  logic               word_drop;
  logic [1:0]         drop_inc;
  logic [OVF_W:0]     drop_sum;
  logic [OVF_W-1:0]   drop_next;

  // ---------------------------------------------------------------------------
  // Event timestamping
  // ---------------------------------------------------------------------------
  always_comb begin
    ev_fine = fine_code;
    if (fine_error) begin
      ev_fine = '0;
    end
  end

  assign ev_ts = {coarse, ev_fine};
  assign ev_le = fine_valid && !fine_edge;
  assign ev_te = fine_valid && fine_edge;

  // ---------------------------------------------------------------------------
  // Pairing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ts_le      <= '0;
      err_le     <= 1'b0;
      timer      <= '0;
      pend_tot   <= '0;
      pend_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A TE here is an orphan; it is only counted by the drop logic.
          if (ev_le) begin
            ts_le  <= ev_ts;
            err_le <= fine_error;
            timer  <= '0;
            state  <= ST_WAIT_TE;
          end
        end

        ST_WAIT_TE: begin
          // The TE is checked before the timer so a TE on the expiry cycle
          // closes the hit normally.
          if (ev_te) begin
            pend_tot                <= ev_ts - ts_le;
            pend_flags              <= '0;
            pend_flags[FLAG_LE_ERR] <= err_le;
            pend_flags[FLAG_TE_ERR] <= fine_error;
            state                   <= ST_PUSH;
          end else if (ev_le) begin
            ts_le  <= ev_ts;
            err_le <= fine_error;
            timer  <= '0;
          end else if (timer == TMR_LAST) begin
            pend_tot                 <= '0;
            pend_flags               <= '0;
            pend_flags[FLAG_LE_ERR]  <= err_le;
            pend_flags[FLAG_TIMEOUT] <= 1'b1;
            state                    <= ST_PUSH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_PUSH: begin
          // Single cycle: the word is either buffered or dropped, never held.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  assign fifo_pop    = hit_valid && hit_ready;
  assign push_accept = !fifo_full || fifo_pop;
  assign fifo_push   = (state == ST_PUSH) && push_accept;
  assign fifo_wdata  = {ts_le, pend_tot, pend_flags};

  tot_hit_fifo2 #(
    .W (HIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hit_valid = !fifo_empty;
  assign hit_toa   = fifo_rdata[TOA_LSB +: TS_W];
  assign hit_tot   = fifo_rdata[TOT_LSB +: TS_W];
  assign hit_flags = fifo_rdata[0 +: FLAGS_W];

  // ---------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------
  // An event seen during PUSH and a word rejected by a full buffer can occur
  // in the same cycle, so the increment can be 2.
  always_comb begin
    ev_drop   = 1'b0;
    word_drop = 1'b0;
    if (fine_valid) begin
      case (state)
        ST_IDLE:    ev_drop = fine_edge;
        ST_WAIT_TE: ev_drop = !fine_edge;
        ST_PUSH:    ev_drop = 1'b1;
        default:    ev_drop = 1'b0;
      endcase
    end
    if ((state == ST_PUSH) && !push_accept) begin
      word_drop = 1'b1;
    end
  end

  assign drop_inc = {1'b0, ev_drop} + {1'b0, word_drop};
  assign drop_sum = {1'b0, drop_cnt} + (OVF_W + 1)'(drop_inc);

  // The carry bit means the sum passed the all-ones maximum.
  always_comb begin
    drop_next = drop_sum[OVF_W-1:0];
    if (drop_sum[OVF_W]) begin
      drop_next = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
    end
  end

endmodule

// File: tb/tb_tot_hit_assembler.sv
// tb/tb_tot_hit_assembler.sv - self-checking bench for tot_hit_assembler
module tb_tot_hit_assembler;

  localparam int COARSE_W = 10;
  localparam int TIMEOUT  = 64;
  localparam int OVF_W    = 8;
  localparam int TS_W     = COARSE_W + 5;
  localparam int DROP_MAX = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                fine_valid = 1'b0;
  logic                fine_edge = 1'b0;
  logic [4:0]          fine_code = '0;
  logic                fine_error = 1'b0;
  logic [COARSE_W-1:0] coarse = '0;
  logic                hit_ready = 1'b0;
  logic                hit_valid;
  logic [TS_W-1:0]     hit_toa;
  logic [TS_W-1:0]     hit_tot;
  logic [2:0]          hit_flags;
  logic [OVF_W-1:0]    drop_cnt;
  logic                busy;

  tot_hit_assembler #(
    .COARSE_W (COARSE_W),
    .TIMEOUT  (TIMEOUT),
    .OVF_W    (OVF_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fine_valid (fine_valid),
    .fine_edge  (fine_edge),
    .fine_code  (fine_code),
    .fine_error (fine_error),
    .coarse     (coarse),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_toa    (hit_toa),
    .hit_tot    (hit_tot),
    .hit_flags  (hit_flags),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a pending pulse, a pending word awaiting buffering, a
  // queue of buffered words and a drop count, advanced once per clock edge.
  typedef struct packed {
    logic [TS_W-1:0] toa;
    logic [TS_W-1:0] tot;
    logic [2:0]      flags;
  } hit_t;

  hit_t            mq[$];
  bit              m_le;
  bit              m_pp;
  logic [TS_W-1:0] m_le_ts;
  bit              m_le_err;
  int              m_le_cyc;
  hit_t            m_word;
  int              m_drop;
  int              now;

  task automatic model_clear();
    mq.delete();
    m_le   = 1'b0;
    m_pp   = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input logic [4:0] c, input bit er,
                            input logic [COARSE_W-1:0] crs, input bit rdy);
    logic [TS_W-1:0] ts;
    bit pop;
    int drops;
    now++;
    ts    = {crs, (er ? 5'd0 : c)};
    drops = 0;
    pop   = (mq.size() > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (m_pp) begin
      if (v) drops++;
      if (mq.size() < 2) mq.push_back(m_word);
      else drops++;
      m_pp = 1'b0;
    end else if (m_le) begin
      if (v && e) begin
        m_word.toa   = m_le_ts;
        m_word.tot   = ts - m_le_ts;
        m_word.flags = {1'b0, er, m_le_err};
        m_pp = 1'b1;
        m_le = 1'b0;
      end else if (v) begin
        m_le_ts  = ts;
        m_le_err = er;
        m_le_cyc = now;
        drops++;
      end else if (now - m_le_cyc == TIMEOUT) begin
        m_word.toa   = m_le_ts;
        m_word.tot   = '0;
        m_word.flags = {1'b1, 1'b0, m_le_err};
        m_pp = 1'b1;
        m_le = 1'b0;
      end
    end else if (v) begin
      if (!e) begin
        m_le     = 1'b1;
        m_le_ts  = ts;
        m_le_err = er;
        m_le_cyc = now;
      end else begin
        drops++;
      end
    end
    m_drop = (m_drop + drops > DROP_MAX) ? DROP_MAX : m_drop + drops;
  endtask

  task automatic cycle(input bit v, input bit e, input logic [4:0] c, input bit er,
                       input logic [COARSE_W-1:0] crs, input bit rdy);
    fine_valid = v;
    fine_edge  = e;
    fine_code  = c;
    fine_error = er;
    coarse     = crs;
    hit_ready  = rdy;
    @(posedge clk);
    model_step(v, e, c, er, crs, rdy);
    #1;
    fine_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, 1'b0, 5'd0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    fine_valid = 1'b0;
    hit_ready  = 1'b0;
    rst_n      = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fine_valid = 1'b0;
    hit_ready  = 1'b0;
    rst_n      = 1'b0;
    model_clear();
    #2;
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", hit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if ({hit_toa, hit_tot, hit_flags} !== '0) begin errors++; $display("FAIL reset_word got=%0h exp=0", {hit_toa, hit_tot, hit_flags}); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pair();
    cycle(1'b1, 1'b0, 5'd3, 1'b0, 10'd5, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 5'd10, 1'b0, 10'd7, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_latency1 got valid=%0b busy=%0b exp valid=0 busy=1", hit_valid, busy); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", hit_valid); end
    checks++; if (hit_toa !== 15'd163) begin errors++; $display("FAIL basic_toa got=%0d exp=163", hit_toa); end
    checks++; if (hit_tot !== 15'd71) begin errors++; $display("FAIL basic_tot got=%0d exp=71", hit_tot); end
    checks++; if (hit_flags !== 3'b000) begin errors++; $display("FAIL basic_flags got=%b exp=000", hit_flags); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain got valid=%0b busy=%0b exp 0 0", hit_valid, busy); end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b0, 5'd30, 1'b0, 10'd1023, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 1'b1, 5'd2, 1'b0, 10'd1, 1'b1);
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%0b exp=1", hit_valid); end
    checks++; if (hit_toa !== 15'd32766) begin errors++; $display("FAIL wrap_toa got=%0d exp=32766", hit_toa); end
    checks++; if (hit_tot !== 15'd36 || hit_flags !== 3'b000) begin errors++; $display("FAIL wrap_tot got tot=%0d flags=%b exp tot=36 flags=000", hit_tot, hit_flags); end
    idle(1, 1'b1);
  endtask

  task automatic test_timeout();
    // LE only: closed by the timer
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 10'd100, 1'b1);
    idle(TIMEOUT, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_pending got valid=%0b busy=%0b exp valid=0 busy=1", hit_valid, busy); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got=%0b exp=1", hit_valid); end
    checks++; if (hit_toa !== 15'd3200 || hit_tot !== 15'd0) begin errors++; $display("FAIL timeout_word got toa=%0d tot=%0d exp toa=3200 tot=0", hit_toa, hit_tot); end
    checks++; if (hit_flags !== 3'b100) begin errors++; $display("FAIL timeout_flags got=%b exp=100", hit_flags); end
    idle(1, 1'b1);
    // TE landing on the expiry cycle wins over the timer
    cycle(1'b1, 1'b0, 5'd1, 1'b0, 10'd200, 1'b1);
    idle(TIMEOUT - 1, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL expiry_waiting got valid=%0b busy=%0b exp valid=0 busy=1", hit_valid, busy); end
    cycle(1'b1, 1'b1, 5'd4, 1'b0, 10'd202, 1'b1);
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1 || hit_toa !== 15'd6401) begin errors++; $display("FAIL expiry_valid got valid=%0b toa=%0d exp valid=1 toa=6401", hit_valid, hit_toa); end
    checks++; if (hit_tot !== 15'd67 || hit_flags !== 3'b000) begin errors++; $display("FAIL expiry_word got tot=%0d flags=%b exp tot=67 flags=000", hit_tot, hit_flags); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL expiry_single got valid=%0b busy=%0b exp 0 0", hit_valid, busy); end
  endtask

  task automatic test_errors();
    cycle(1'b1, 1'b1, 5'd9, 1'b0, 10'd50, 1'b1);
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL orphan_nohit got valid=%0b busy=%0b exp 0 0", hit_valid, busy); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL orphan_drop got=%0d exp=1", drop_cnt); end
    cycle(1'b1, 1'b0, 5'd7, 1'b1, 10'd3, 1'b1);
    idle(1, 1'b1);
    cycle(1'b1, 1'b1, 5'd5, 1'b0, 10'd4, 1'b1);
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1 || hit_flags !== 3'b001) begin errors++; $display("FAIL leerr_flags got valid=%0b flags=%b exp valid=1 flags=001", hit_valid, hit_flags); end
    checks++; if (hit_toa !== 15'd96 || hit_tot !== 15'd37) begin errors++; $display("FAIL leerr_word got toa=%0d tot=%0d exp toa=96 tot=37", hit_toa, hit_tot); end
    idle(1, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(1'b1, 1'b0, 5'd1, 1'b0, 10'd10, 1'b0);
    cycle(1'b1, 1'b1, 5'd9, 1'b0, 10'd10, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b0, 5'd2, 1'b0, 10'd20, 1'b0);
    cycle(1'b1, 1'b1, 5'd20, 1'b0, 10'd20, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b0, 5'd3, 1'b0, 10'd30, 1'b0);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 10'd31, 1'b0);
    idle(1, 1'b0);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop got=%0d exp=1", drop_cnt); end
    checks++; if (hit_valid !== 1'b1 || hit_toa !== 15'd321 || hit_tot !== 15'd8) begin errors++; $display("FAIL bp_head got valid=%0b toa=%0d tot=%0d exp valid=1 toa=321 tot=8", hit_valid, hit_toa, hit_tot); end
    idle(3, 1'b0);
    checks++; if (hit_valid !== 1'b1 || hit_toa !== 15'd321 || hit_tot !== 15'd8 || hit_flags !== 3'b000) begin errors++; $display("FAIL bp_stable got valid=%0b toa=%0d tot=%0d flags=%b exp 1 321 8 000", hit_valid, hit_toa, hit_tot, hit_flags); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1 || hit_toa !== 15'd642 || hit_tot !== 15'd18) begin errors++; $display("FAIL bp_second got valid=%0b toa=%0d tot=%0d exp valid=1 toa=642 tot=18", hit_valid, hit_toa, hit_tot); end
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", hit_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 10'd1, 1'b0);
    cycle(1'b1, 1'b0, 5'd1, 1'b0, 10'd2, 1'b0);
    cycle(1'b1, 1'b1, 5'd2, 1'b0, 10'd2, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b0, 5'd3, 1'b0, 10'd3, 1'b0);
    checks++; if (hit_valid !== 1'b1 || busy !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_pre got valid=%0b busy=%0b drop=%0d exp 1 1 1", hit_valid, busy, drop_cnt); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (hit_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_clear got valid=%0b busy=%0b drop=%0d exp 0 0 0", hit_valid, busy, drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 5'd6, 1'b0, 10'd40, 1'b1);
    cycle(1'b1, 1'b1, 5'd1, 1'b0, 10'd41, 1'b1);
    idle(1, 1'b1);
    checks++; if (hit_valid !== 1'b1 || hit_toa !== 15'd1286 || hit_tot !== 15'd27 || hit_flags !== 3'b000) begin errors++; $display("FAIL rstmid_after got valid=%0b toa=%0d tot=%0d flags=%b exp 1 1286 27 000", hit_valid, hit_toa, hit_tot, hit_flags); end
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    int dens;
    bit v, e, er, rdy;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      dens = (i < 1500) ? 3 : 50;
      v    = ($urandom_range(0, dens - 1) == 0);
      e    = $urandom_range(0, 1) == 1;
      er   = ($urandom_range(0, 15) == 0);
      rdy  = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      cycle(v, e, 5'($urandom_range(0, 31)), er, COARSE_W'($urandom_range(0, 1023)), rdy);
      checks++; if (hit_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, hit_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if ({hit_toa, hit_tot, hit_flags} !== mq[0]) begin errors++; $display("FAIL rand_word cyc=%0d got=%0h exp=%0h", i, {hit_toa, hit_tot, hit_flags}, mq[0]); end
      end
      checks++; if (busy !== (m_le || m_pp)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", i, busy, m_le || m_pp); end
      checks++; if (drop_cnt !== OVF_W'(m_drop)) begin errors++; $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", i, drop_cnt, m_drop); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      cycle(1'b1, 1'b1, 5'd0, 1'b0, '0, 1'b1);
      if (i == 254 || i == 255 || i == 300) begin
        checks++; if (drop_cnt !== OVF_W'((i > DROP_MAX) ? DROP_MAX : i)) begin errors++; $display("FAIL sat_drop n=%0d got=%0d exp=%0d", i, drop_cnt, (i > DROP_MAX) ? DROP_MAX : i); end
      end
    end
  endtask

  initial begin
    now = 0;
    model_clear();
    #1;
    test_reset();
    test_basic_pair();
    test_wrap();
    test_timeout();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tot_hit_assembler.md
Name: tot_hit_assembler

Overview:
- Sequential stage directly downstream of the TOT fine encoder core.
- Pairs leading-edge (LE) and trailing-edge (TE) fine codes (5-bit bin, 32 bins per coarse period) with the coarse counter value.
- Computes the time-over-threshold and arrival time, and delivers one hit word per pulse through a valid/ready interface backed by a 2-entry buffer.
- Sits between the fine encoder and the hit readout/serializer.

Parameters:
- COARSE_W, 10, coarse counter width; timestamp width TS_W = COARSE_W+5.
- TIMEOUT, 64, cycles to wait for a TE after an LE before closing the hit.
- OVF_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- fine_valid  in  1  fine code present this cycle.
- fine_edge  in  1  0 = leading edge, 1 = trailing edge.
- fine_code  in  5  fine encoder binary output.
- fine_error  in  1  fine encoder error flag.
- coarse  in  COARSE_W  coarse count sampled with this edge.
- hit_valid  out  1  hit word available.
- hit_ready  in  1  consumer accepts the word.
- hit_toa  out  TS_W  LE timestamp {coarse,fine}.
- hit_tot  out  TS_W  TE timestamp minus LE timestamp, modulo 2^TS_W.
- hit_flags  out  3  bit0 = LE fine error, bit1 = TE fine error, bit2 = timeout.
- drop_cnt  out  OVF_W  saturating count of dropped events.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM IDLE, buffer empty, timer 0.
- Timestamp of an event: ts = {coarse, fine_code}.
- A fine_error event uses fine = 0 and sets the matching flag bit.

FSM states: IDLE, WAIT_TE, PUSH.
- IDLE, LE event: latch ts_le and err_le, clear the timer, go to WAIT_TE.
- IDLE, TE event: orphan; discard and increment drop_cnt; stay in IDLE.
- WAIT_TE, TE event: tot = ts_te - ts_le, wrap-around allowed (unsigned modulo); go to PUSH.
- WAIT_TE, LE event: the new LE replaces the old one (re-latch, timer cleared); drop_cnt increments; stay in WAIT_TE.
- WAIT_TE timer: increments each cycle. When it reaches TIMEOUT-1 with no TE, go to PUSH with tot = 0 and flag bit2 set.
- WAIT_TE, TE arriving in the same cycle the timer expires: the TE wins and no timeout is flagged.
- PUSH, buffer not full: write {toa, tot, flags} and return to IDLE. Total latency from TE fine_valid to hit_valid is 2 cycles with the buffer empty.
- PUSH, buffer full: the word is discarded, drop_cnt increments, return to IDLE. PUSH never stalls.
- Any fine_valid event arriving while in PUSH is discarded and counted.

Output buffer:
- 2-entry FIFO; head word drives hit_* outputs.
- hit_valid = !empty.
- Pop when hit_valid && hit_ready.
- A push and a pop in the same cycle with the buffer full is allowed: the pop frees space first, so the word is accepted.
- Outputs stay stable while hit_valid=1 and hit_ready=0.

drop_cnt: saturates at 2^OVF_W-1 and never wraps.

Reset asserted mid-operation: asynchronous clear of the FSM, buffer contents, counters and all outputs. The first edge after rst_n deasserts is processed normally.

Decomposition:
- Shared package tot_pkg holds: FINE_W=5, the flag bit indices (FLAG_LE_ERR, FLAG_TE_ERR, FLAG_TIMEOUT), the FSM state encoding, and the hit word layout {toa, tot, flags}.
- One sub-module, tot_hit_fifo2: 2-entry synchronous FIFO with async active-low reset, push/pop/full/empty.

Test Plan:
- Basic pair: LE coarse=5 fine=3, TE 4 cycles later coarse=7 fine=10, hit_ready=1 -> one hit 2 cycles after the TE, toa=163, tot=71, flags=0.
- Wrap-around: COARSE_W=10, LE coarse=1023 fine=30, TE coarse=1 fine=2 -> tot=36, flags=0.
- Timeout: LE only -> after TIMEOUT cycles hit with tot=0 and flags=3'b100. TE arriving exactly on the expiry cycle -> normal tot and flags=0.
- Errors and orphans: TE in IDLE -> no hit, drop_cnt=1. LE with fine_error=1 then a clean TE -> flags=3'b001, toa fine field 0.
- Backpressure: hit_ready=0, send 3 complete pulses -> 2 words buffered unchanged, drop_cnt=1. Raise hit_ready -> words pop in order, hit_valid falls after the second.
- Reset: assert rst_n=0 while in WAIT_TE with 1 word buffered -> hit_valid=0, busy=0, drop_cnt=0 immediately. Next clean pulse after release produces a correct hit.
